// File: rtl/gcd_pkg.sv
// Shared definitions for the binary-GCD engine: FSM state encoding and default width.
package gcd_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REDUCE = 2'd1,
        ST_ITER   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/gcd_stein_step.sv
// One combinational Stein iteration: halve an even operand or halve the difference
// of two odd operands; flags equality once both are odd and identical.
module gcd_stein_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_nextA,
    output logic [WIDTH-1:0] o_nextB,
    output logic             o_equal
);

    logic [WIDTH-1:0] w_diffAB;
    logic [WIDTH-1:0] w_diffBA;

    // The larger operand is always the minuend, so neither difference underflows where used.
    assign w_diffAB = i_a - i_b;
    assign w_diffBA = i_b - i_a;

    always_comb begin
        o_nextA = i_a;
        o_nextB = i_b;
        o_equal = 1'b0;
        if (!i_a[0]) begin
            o_nextA = i_a >> 1;
        end else if (!i_b[0]) begin
            o_nextB = i_b >> 1;
        end else if (i_a > i_b) begin
            o_nextA = w_diffAB >> 1;
        end else if (i_b > i_a) begin
            o_nextB = w_diffBA >> 1;
        end else begin
            o_equal = 1'b1;
        end
    end

endmodule

// File: rtl/gcd_stein_engine.sv
// Sequential binary (Stein) GCD engine with valid/ready handshakes on input and output.
// Strips common factors of two into k, iterates to a==b, then returns a<<k.
module gcd_stein_engine
    import gcd_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] num1,
    input  logic [WIDTH-1:0] num2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] gcd_result,
    output logic             coprime,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_t           r_state;
    state_t           w_nextState;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [CNT_W-1:0] r_k;
    logic [WIDTH-1:0] r_gcd;
    logic             r_coprime;
    logic             r_outValid;
    logic             r_busy;

    logic [WIDTH-1:0] w_nextA;
    logic [WIDTH-1:0] w_nextB;
    logic             w_equal;
    logic             w_zeroOp;
    logic [WIDTH-1:0] w_shifted;
    logic [WIDTH-1:0] w_zeroGcd;

    assign w_zeroOp  = (num1 == '0) || (num2 == '0);
    assign w_zeroGcd = num1 | num2;
    assign w_shifted = r_a << r_k;

    gcd_stein_step #(.WIDTH(WIDTH)) u_step (
        .i_a     (r_a),
        .i_b     (r_b),
        .o_nextA (w_nextA),
        .o_nextB (w_nextB),
        .o_equal (w_equal)
    );

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_nextState = w_zeroOp ? ST_DONE : ST_REDUCE;
                end
            end
            ST_REDUCE: begin
                if (r_a[0] || r_b[0]) begin
                    w_nextState = ST_ITER;
                end
            end
            ST_ITER: begin
                if (w_equal) begin
                    w_nextState = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_nextState = ST_IDLE;
                end
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    // Handshake flags are registered from the next state so they line up with r_state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_k        <= '0;
            r_gcd      <= '0;
            r_coprime  <= 1'b0;
            r_outValid <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_outValid <= (w_nextState == ST_DONE);
            r_busy     <= (w_nextState == ST_REDUCE) || (w_nextState == ST_ITER);
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a <= num1;
                        r_b <= num2;
                        r_k <= '0;
                        if (w_zeroOp) begin
                            r_gcd     <= w_zeroGcd;
                            r_coprime <= (w_zeroGcd == WIDTH'(1));
                        end
                    end
                end
                ST_REDUCE: begin
                    if (!r_a[0] && !r_b[0]) begin
                        r_a <= r_a >> 1;
                        r_b <= r_b >> 1;
                        r_k <= r_k + CNT_W'(1);
                    end
                end
                ST_ITER: begin
                    r_a <= w_nextA;
                    r_b <= w_nextB;
                    if (w_equal) begin
                        r_gcd     <= w_shifted;
                        r_coprime <= (w_shifted == WIDTH'(1));
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready   = (r_state == ST_IDLE);
    assign out_valid  = r_outValid;
    assign gcd_result = r_gcd;
    assign coprime    = r_coprime;
    assign busy       = r_busy;

endmodule
